// File: rtl/lpm_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lpm_ram_pkg
// Brief    : Mode strings, FSM state type and configuration helpers for the
//            simple-dual-port byte-enable RAM.
// Revision : 1.0
// ============================================================================
package lpm_ram_pkg;

    localparam string OUTDATA_REGISTERED   = "REGISTERED";
    localparam string OUTDATA_UNREGISTERED = "UNREGISTERED";
    localparam string RDW_OLD_DATA         = "OLD_DATA";
    localparam string RDW_NEW_DATA         = "NEW_DATA";
    localparam string CLEAR_ON             = "ON";
    localparam string CLEAR_OFF            = "OFF";

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } ram_state_e;

    function automatic int byte_lanes(input int width, input int byte_size);
        return width / byte_size;
    endfunction

    function automatic bit width_ok(input int width, input int byte_size);
        return (byte_size > 0) && (width > 0) && ((width % byte_size) == 0);
    endfunction

    // The address bus must be exactly as wide as the word count requires.
    function automatic bit numwords_ok(input int numwords, input int widthad);
        return (widthad > 0) && (numwords > 1) && (numwords <= (1 << widthad)) &&
               ($clog2(numwords) == widthad);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpm_ram_sdp_core.sv
`default_nettype none
// ============================================================================
// Module   : lpm_ram_sdp_core
// Brief    : Plain storage array, byte-lane write port and registered read
//            port; no reset, reads always return pre-write contents.
// Revision : 1.0
// ============================================================================
module lpm_ram_sdp_core #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 8,
    parameter int NUMWORDS  = 256,
    parameter int BYTE_SIZE = 8
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [WIDTH-1:0]              wdata,
    input  logic [WIDTH/BYTE_SIZE-1:0]    wbe,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             raddr,
    output logic [WIDTH-1:0]              rdata
);

    localparam int LANES = WIDTH / BYTE_SIZE;

    logic [WIDTH-1:0] r_mem [NUMWORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (wbe[k]) begin
                    r_mem[waddr][k*BYTE_SIZE +: BYTE_SIZE] <= wdata[k*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/lpm_ram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module   : lpm_ram_sdp_be
// Brief    : Simple-dual-port RAM with byte enables, post-reset clear sweep,
//            selectable read latency and read-during-write policy.
// Revision : 1.0
// ============================================================================
module lpm_ram_sdp_be
    import lpm_ram_pkg::*;
#(
    parameter int    lpm_width      = 32,
    parameter int    lpm_widthad    = 8,
    parameter int    lpm_numwords   = 1 << lpm_widthad,
    parameter int    lpm_byte_size  = 8,
    parameter string lpm_outdata    = "REGISTERED",
    parameter string rdw_mode       = "OLD_DATA",
    parameter string clear_on_reset = "ON"
) (
    input  logic                                clock,
    input  logic                                aclr_n,
    input  logic                                wren,
    input  logic [lpm_widthad-1:0]              wraddress,
    input  logic [lpm_width-1:0]                data,
    input  logic [lpm_width/lpm_byte_size-1:0]  byteena,
    input  logic                                rden,
    input  logic [lpm_widthad-1:0]              rdaddress,
    output logic [lpm_width-1:0]                q,
    output logic                                q_valid,
    output logic                                busy,
    output logic                                addr_err
);

    localparam int  LANES   = byte_lanes(lpm_width, lpm_byte_size);
    localparam bit  OUT_REG = (lpm_outdata == OUTDATA_REGISTERED);
    localparam bit  RDW_NEW = (rdw_mode == RDW_NEW_DATA);
    localparam bit  CLR_ON  = (clear_on_reset == CLEAR_ON);
    localparam logic [lpm_widthad-1:0] LAST_ADDR   = lpm_widthad'(lpm_numwords - 1);
    localparam logic [lpm_widthad:0]   NUMWORDS_EX = (lpm_widthad + 1)'(lpm_numwords);

    if (!width_ok(lpm_width, lpm_byte_size)) begin : g_err_width
        $error("lpm_width must be a non-zero multiple of lpm_byte_size");
    end
    if (!numwords_ok(lpm_numwords, lpm_widthad)) begin : g_err_numwords
        $error("ceil(log2(lpm_numwords)) must equal lpm_widthad");
    end
    if (!OUT_REG && (lpm_outdata != OUTDATA_UNREGISTERED)) begin : g_err_outdata
        $error("lpm_outdata must be REGISTERED or UNREGISTERED");
    end
    if (!RDW_NEW && (rdw_mode != RDW_OLD_DATA)) begin : g_err_rdw
        $error("rdw_mode must be OLD_DATA or NEW_DATA");
    end
    if (!CLR_ON && (clear_on_reset != CLEAR_OFF)) begin : g_err_clear
        $error("clear_on_reset must be ON or OFF");
    end

    ram_state_e              r_state;
    ram_state_e              w_state_nxt;
    logic [lpm_widthad-1:0]  r_sweep;
    logic [lpm_widthad-1:0]  w_sweep_nxt;
    logic                    w_clr_we;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            if (CLR_ON) begin
                r_state <= ST_CLEAR;
            end else begin
                r_state <= ST_RUN;
            end
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_sweep == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep + lpm_widthad'(1);
                end
            end
            default: begin
            end
        endcase
    end

    logic w_run;
    logic w_wr_acc;
    logic w_rd_acc;
    logic w_wr_inr;
    logic w_rd_inr;
    logic w_wr_ok;
    logic w_collide;

    assign w_run     = (r_state == ST_RUN);
    assign busy      = ~w_run;
    assign w_wr_acc  = w_run & wren;
    assign w_rd_acc  = w_run & rden;
    assign w_wr_inr  = ({1'b0, wraddress} < NUMWORDS_EX);
    assign w_rd_inr  = ({1'b0, rdaddress} < NUMWORDS_EX);
    assign w_wr_ok   = w_wr_acc & w_wr_inr;
    assign w_collide = w_wr_ok & (wraddress == rdaddress);

    logic                    w_core_we;
    logic [lpm_widthad-1:0]  w_core_waddr;
    logic [lpm_width-1:0]    w_core_wdata;
    logic [LANES-1:0]        w_core_wbe;
    logic [lpm_width-1:0]    w_core_rdata;

    // The clear sweep owns the write port; user writes cannot occur then anyway.
    assign w_core_we    = w_clr_we | w_wr_ok;
    assign w_core_waddr = w_clr_we ? r_sweep : wraddress;
    assign w_core_wdata = w_clr_we ? '0 : data;
    assign w_core_wbe   = w_clr_we ? '1 : byteena;

    lpm_ram_sdp_core #(
        .WIDTH     (lpm_width),
        .ADDR_W    (lpm_widthad),
        .NUMWORDS  (lpm_numwords),
        .BYTE_SIZE (lpm_byte_size)
    ) u_core (
        .clk   (clock),
        .we    (w_core_we),
        .waddr (w_core_waddr),
        .wdata (w_core_wdata),
        .wbe   (w_core_wbe),
        .re    (w_rd_acc & w_rd_inr),
        .raddr (rdaddress),
        .rdata (w_core_rdata)
    );

    logic                  r_s1_valid;
    logic                  r_s1_zero;
    logic                  r_s1_byp;
    logic [lpm_width-1:0]  r_s1_data;
    logic [LANES-1:0]      r_s1_be;
    logic [lpm_width-1:0]  w_s1_word;

    // r_s1_zero starts set so q reads 0 until the first read lands.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_s1_valid <= 1'b0;
            r_s1_zero  <= 1'b1;
            r_s1_byp   <= 1'b0;
            r_s1_data  <= '0;
            r_s1_be    <= '0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_zero <= ~w_rd_inr;
                r_s1_byp  <= RDW_NEW & w_collide;
                r_s1_data <= data;
                r_s1_be   <= byteena;
            end
        end
    end

    always_comb begin
        w_s1_word = w_core_rdata;
        if (r_s1_byp) begin
            for (int k = 0; k < LANES; k++) begin
                if (r_s1_be[k]) begin
                    w_s1_word[k*lpm_byte_size +: lpm_byte_size] = r_s1_data[k*lpm_byte_size +: lpm_byte_size];
                end
            end
        end
        if (r_s1_zero) begin
            w_s1_word = '0;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [lpm_width-1:0] r_q;
        logic                 r_q_valid;

        always_ff @(posedge clock or negedge aclr_n) begin
            if (!aclr_n) begin
                r_q       <= '0;
                r_q_valid <= 1'b0;
            end else begin
                r_q_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_q <= w_s1_word;
                end
            end
        end

        assign q       = r_q;
        assign q_valid = r_q_valid;
    end else begin : g_out_unreg
        assign q       = w_s1_word;
        assign q_valid = r_s1_valid;
    end

    logic r_addr_err;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_addr_err <= 1'b0;
        end else if ((w_wr_acc & ~w_wr_inr) | (w_rd_acc & ~w_rd_inr)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_lpm_ram_sdp_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpm_ram_sdp_be
// Brief    : Scoreboard bench driving two RAM configurations with shared stimulus.
// Revision : 1.0
// ============================================================================
module tb_lpm_ram_sdp_be;

    logic        clk = 1'b0;
    logic        aclr_n = 1'b1;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic [7:0]  wraddress = '0;
    logic [7:0]  rdaddress = '0;
    logic [31:0] data = '0;
    logic [3:0]  byteena = '0;

    logic [31:0] q_o    [2];
    logic        qv_o   [2];
    logic        busy_o [2];
    logic        aerr_o [2];

    always #5 clk = ~clk;

    // Instance 0: defaults (REGISTERED, OLD_DATA, 256 words)
    lpm_ram_sdp_be u_dut_a (
        .clock(clk), .aclr_n(aclr_n), .wren(wren), .wraddress(wraddress),
        .data(data), .byteena(byteena), .rden(rden), .rdaddress(rdaddress),
        .q(q_o[0]), .q_valid(qv_o[0]), .busy(busy_o[0]), .addr_err(aerr_o[0])
    );

    // Instance 1: UNREGISTERED, NEW_DATA, 200 words
    lpm_ram_sdp_be #(
        .lpm_numwords(200), .lpm_outdata("UNREGISTERED"), .rdw_mode("NEW_DATA")
    ) u_dut_b (
        .clock(clk), .aclr_n(aclr_n), .wren(wren), .wraddress(wraddress),
        .data(data), .byteena(byteena), .rden(rden), .rdaddress(rdaddress),
        .q(q_o[1]), .q_valid(qv_o[1]), .busy(busy_o[1]), .addr_err(aerr_o[1])
    );

    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int          cyc    = 0;

    int   nw   [2] = '{256, 200};
    int   xlat [2] = '{1, 0};      // edges after the issue edge before q_valid shows
    bit   newd [2] = '{1'b0, 1'b1};

    logic [31:0] mem    [2][256];
    int          bcnt   [2];
    bit          m_aerr [2];
    logic [31:0] m_q    [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) r[k*8 +: 8] = nd[k*8 +: 8];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            bcnt[i]   = nw[i];
            m_aerr[i] = 1'b0;
            m_q[i]    = '0;
            for (int a = 0; a < 256; a++) mem[i][a] = '0;
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (bcnt[i] > 0) begin
                bcnt[i]--;
            end else begin
                bit   wr_ok;
                bit   rd_inr;
                exp_t e;
                wr_ok  = wren && (int'(wraddress) < nw[i]);
                rd_inr = int'(rdaddress) < nw[i];
                if (rden) begin
                    e.due = cyc + xlat[i];
                    if (!rd_inr) begin
                        e.d = '0;
                    end else begin
                        e.d = mem[i][rdaddress];
                        if (newd[i] && wr_ok && (wraddress == rdaddress))
                            e.d = merge(e.d, data, byteena);
                    end
                    if (i == 0) sbq0.push_back(e);
                    else        sbq1.push_back(e);
                end
                if ((wren && !(int'(wraddress) < nw[i])) || (rden && !rd_inr))
                    m_aerr[i] = 1'b1;
                if (wr_ok)
                    mem[i][wraddress] = merge(mem[i][wraddress], data, byteena);
            end
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 2; i++) begin
            bit   ev;
            exp_t e;
            ev = 1'b0;
            if (i == 0 && sbq0.size() > 0 && sbq0[0].due == cyc) begin
                e = sbq0.pop_front();
                ev = 1'b1;
            end else if (i == 1 && sbq1.size() > 0 && sbq1[0].due == cyc) begin
                e = sbq1.pop_front();
                ev = 1'b1;
            end
            if (ev) m_q[i] = e.d;
            chk($sformatf("q_valid[%0d]", i), 32'(qv_o[i]), 32'(ev));
            chk($sformatf("q[%0d]", i), q_o[i], m_q[i]);
            chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(bcnt[i] > 0));
            chk($sformatf("addr_err[%0d]", i), 32'(aerr_o[i]), 32'(m_aerr[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (aclr_n) model_edge();
        #1;
        check_outputs();
    endtask

    task automatic pulse_reset(input int hold);
        aclr_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (hold) cycle();
        aclr_n = 1'b1;
    endtask

    task automatic idle(input int n);
        wren = 1'b0;
        rden = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic set_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wren = 1'b1; wraddress = a; data = d; byteena = be;
    endtask

    task automatic set_rd(input logic [7:0] a);
        rden = 1'b1; rdaddress = a;
    endtask

    task automatic wr1(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        set_wr(a, d, be);
        rden = 1'b0;
        cycle();
        wren = 1'b0;
    endtask

    task automatic rd1(input logic [7:0] a);
        wren = 1'b0;
        set_rd(a);
        cycle();
        idle(3);
    endtask

    initial begin
        #2;
        pulse_reset(3);

        // Clear sweep window: requests during busy must be ignored
        for (int k = 0; k < 260; k++) begin
            if (k < 190) begin
                set_wr(8'(k), 32'hFFFF_FFFF, 4'hF);
                set_rd(8'(k));
            end else begin
                wren = 1'b0;
                rden = 1'b0;
            end
            cycle();
        end
        rd1(8'd0);
        rd1(8'd127);
        rd1(8'd255);

        // Byte-lane merge
        wr1(8'd5, 32'hDEAD_BEEF, 4'b1111);
        wr1(8'd5, 32'h1122_3344, 4'b0101);
        rd1(8'd5);

        // Read-during-write collision
        wr1(8'd9, 32'hAAAA_AAAA, 4'b1111);
        set_wr(8'd9, 32'h5555_5555, 4'b0011);
        set_rd(8'd9);
        cycle();
        idle(3);
        rd1(8'd9);

        // Back-to-back reads
        for (int a = 0; a < 4; a++) wr1(8'(a), 32'h1000_0000 + 32'(a * 32'h0101), 4'hF);
        for (int a = 0; a < 4; a++) begin
            set_rd(8'(a));
            cycle();
        end
        idle(4);

        // Out-of-range address (only for the 200-word instance)
        wr1(8'd210, 32'h1234_5678, 4'hF);
        rd1(8'd210);
        rd1(8'd82);
        rd1(8'd10);
        idle(10);
        rd1(8'd5);

        // Asynchronous reset clears outputs, then mid-sweep restart
        pulse_reset(2);
        idle(100);
        pulse_reset(2);
        idle(260);
        for (int a = 0; a < 256; a++) begin
            set_rd(8'(a));
            cycle();
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
